// File: rtl/soc_top_if.sv
// soc_top_if: core data-memory port and console read port of soc_top.
// The core side (or a bench) takes master; soc_top takes slave.
interface soc_top_if #(
   parameter int AW = 10
);
   logic [3:0]    dm_write;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic [31:0]   dm_rdata;
   logic [AW-1:0] con_addr;
   logic [31:0]   con_out;

   modport master (
      output dm_write, dm_addr, dm_wdata, con_addr,
      input  dm_rdata, con_out
   );

   modport slave (
      input  dm_write, dm_addr, dm_wdata, con_addr,
      output dm_rdata, con_out
   );
endinterface

// File: rtl/soc_top.sv
// soc_top: 1024x32 data memory with core and console ports, plus a mailbox-fed TX FIFO
// draining through a one-bit-per-cycle UART serializer. Define UART_PARITY_EN for even parity.
module soc_top #(
   parameter int                             DEPTH_WORDS = 1024,
   parameter logic [$clog2(DEPTH_WORDS)-1:0] TX_ADDR     = 10'h3FF,
   parameter int                             FIFO_DEPTH  = 16
) (
   input  logic     uart_clk,
   input  logic     nrst,
   soc_top_if.slave bus,
   output logic     ck_io7,
   output logic     tx_busy,
   output logic     tx_full
);

`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} tx_state_t;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   status;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push_req;
   logic          push_ok;
   logic          pop;

   tx_state_t     state;
   tx_state_t     nxt_state;
   logic [2:0]    bit_idx;
   logic [2:0]    nxt_idx;
   logic [7:0]    tx_data;
   logic          nxt_line;
   logic          nxt_busy;

   assign status = {PAR_EN, 29'b0, tx_full, tx_busy};

   // Memory: byte-lane writes, registered core read, combinational console read
   always_ff @(posedge uart_clk) begin
      if (bus.dm_addr != TX_ADDR) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.dm_write[i]) mem[bus.dm_addr][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge uart_clk) begin
      if (!nrst) bus.dm_rdata <= '0;
      else       bus.dm_rdata <= (bus.dm_addr == TX_ADDR) ? status : mem[bus.dm_addr];
   end

   assign bus.con_out = (bus.con_addr == TX_ADDR) ? status : mem[bus.con_addr];

   // TX FIFO: a full FIFO still accepts a push when the serializer pops in the same cycle
   assign push_req = (bus.dm_addr == TX_ADDR) && bus.dm_write[0];
   assign push_ok  = push_req && ((count != FULL_CNT) || pop);
   assign tx_full  = (count == FULL_CNT);
   assign pop      = (state == IDLE) && (count != '0);

   always_ff @(posedge uart_clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.dm_wdata[7:0];
   end

   always_ff @(posedge uart_clk) begin
      if (!nrst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)      count <= count + CW'(1);
         else if (!push_ok && pop) count <= count - CW'(1);
      end
   end

   // Serializer: state lags the line by one edge, so a pop at edge k drives the start bit from k
   always_ff @(posedge uart_clk) begin
      if (pop) tx_data <= fifo_mem[rd_ptr];
   end

   always_ff @(posedge uart_clk) begin
      if (!nrst) begin
         state   <= IDLE;
         bit_idx <= '0;
         ck_io7  <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= nxt_state;
         bit_idx <= nxt_idx;
         ck_io7  <= nxt_line;
         tx_busy <= nxt_busy;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_idx   = bit_idx;
      nxt_line  = ck_io7;
      nxt_busy  = tx_busy;
      case (state)
         IDLE: begin
            nxt_line = !pop;
            nxt_busy = pop;
            nxt_idx  = '0;
            if (pop) nxt_state = DATA;
         end
         DATA: begin
            nxt_line = tx_data[bit_idx];
            nxt_idx  = bit_idx + 3'd1;
            if (bit_idx == 3'd7) nxt_state = PAR_EN ? PARITY : STOP;
         end
         PARITY: begin
            nxt_line  = ^tx_data;
            nxt_state = STOP;
         end
         STOP: begin
            nxt_line  = 1'b1;
            nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top: directed vectors for soc_top memory ports, mailbox FIFO and UART framing.
// Inputs change and outputs are sampled 1 ns after each rising uart_clk edge.
`timescale 1ns/1ps
module tb_soc_top;
   localparam logic [9:0] TX = 10'h3FF;
`ifdef UART_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam logic [31:0] STAT_IDLE = {PAR, 31'b0};

   logic uart_clk = 1'b0;
   logic nrst     = 1'b0;
   logic ck_io7, tx_busy, tx_full;

   int n_cmp = 0;
   int n_bad = 0;

   soc_top_if #(.AW(10)) bus ();

   soc_top dut (
      .uart_clk (uart_clk),
      .nrst     (nrst),
      .bus      (bus),
      .ck_io7   (ck_io7),
      .tx_busy  (tx_busy),
      .tx_full  (tx_full)
   );

   always #5 uart_clk = ~uart_clk;

   typedef struct {
      logic [3:0]  we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [9:0]  caddr;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_con;
   } mvec_t;

   mvec_t      mv [9];
   logic       sched_en   [32];
   logic [7:0] sched_val  [32];
   int         sched_full [32];
   logic [7:0] exp_bytes  [$];
   logic       exp_bits   [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] we, input logic [9:0] a, input logic [31:0] d,
                        input logic [9:0] ca);
      bus.dm_write = we;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
      bus.con_addr = ca;
   endtask

   task automatic step();
      @(posedge uart_clk);
      #1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 32; i++) begin
         sched_en[i]   = 1'b0;
         sched_val[i]  = 8'h00;
         sched_full[i] = -1;
      end
      exp_bytes.delete();
   endtask

   task automatic build_bits();
      exp_bits.delete();
      foreach (exp_bytes[i]) begin
         exp_bits.push_back(1'b0);
         for (int b = 0; b < 8; b++) exp_bits.push_back(exp_bytes[i][b]);
         if (PAR) exp_bits.push_back(^exp_bytes[i]);
         exp_bits.push_back(1'b1);
      end
   endtask

   // Cycle c pushes sched_val[c] at edge c; line bit n is expected after edge n+1.
   task automatic run_stream(input string name, input int n_sched);
      int nb;
      build_bits();
      nb = exp_bits.size();
      for (int c = 0; c <= nb + 1; c++) begin
         if (c < n_sched && sched_en[c]) drive(4'b0001, TX, {24'h0, sched_val[c]}, TX);
         else                            drive(4'b0000, 10'h000, 32'h0, TX);
         step();
         if (c < n_sched && sched_full[c] >= 0)
            check($sformatf("%s full@%0d", name, c), {31'b0, tx_full}, sched_full[c]);
         if (c == 0) begin
            check($sformatf("%s early line", name), {31'b0, ck_io7}, 32'd1);
         end else if (c <= nb) begin
            check($sformatf("%s bit%0d", name, c - 1), {31'b0, ck_io7}, {31'b0, exp_bits[c-1]});
            check($sformatf("%s busy%0d", name, c - 1), {31'b0, tx_busy}, 32'd1);
         end else begin
            check($sformatf("%s idle line", name), {31'b0, ck_io7}, 32'd1);
            check($sformatf("%s idle busy", name), {31'b0, tx_busy}, 32'd0);
            check($sformatf("%s idle full", name), {31'b0, tx_full}, 32'd0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
      $fatal(1);
   end

   initial begin
      mv[0] = '{4'hF, 10'h010, 32'hDEADBEEF, 10'h010, 1'b0, 32'h0,      32'hDEADBEEF};
      mv[1] = '{4'h2, 10'h010, 32'h00000000, 10'h010, 1'b1, 32'hDEADBEEF, 32'hDEAD00EF};
      mv[2] = '{4'h0, 10'h010, 32'h00000000, 10'h010, 1'b1, 32'hDEAD00EF, 32'hDEAD00EF};
      mv[3] = '{4'hF, 10'h020, 32'h12345678, 10'h020, 1'b0, 32'h0,      32'h12345678};
      mv[4] = '{4'hC, 10'h020, 32'hAABBCCDD, 10'h020, 1'b1, 32'h12345678, 32'hAABB5678};
      mv[5] = '{4'h0, 10'h020, 32'h00000000, 10'h010, 1'b1, 32'hAABB5678, 32'hDEAD00EF};
      mv[6] = '{4'h0, TX,      32'h00000000, TX,      1'b1, STAT_IDLE,  STAT_IDLE};
      mv[7] = '{4'hE, TX,      32'h12345600, 10'h020, 1'b1, STAT_IDLE,  32'hAABB5678};
      mv[8] = '{4'h0, 10'h010, 32'h00000000, TX,      1'b1, 32'hDEAD00EF, STAT_IDLE};

      // Reset
      drive(4'b0000, TX, 32'h0, TX);
      nrst = 1'b0;
      repeat (3) step();
      nrst = 1'b1;
      check("rst line",   {31'b0, ck_io7},  32'd1);
      check("rst busy",   {31'b0, tx_busy}, 32'd0);
      check("rst full",   {31'b0, tx_full}, 32'd0);
      check("rst rdata",  bus.dm_rdata,     32'd0);
      check("rst status", bus.con_out,      STAT_IDLE);

      // Memory vectors
      for (int i = 0; i < 9; i++) begin
         drive(mv[i].we, mv[i].addr, mv[i].wdata, mv[i].caddr);
         step();
         if (mv[i].chk_rd) check($sformatf("mem rdata row%0d", i), bus.dm_rdata, mv[i].exp_rd);
         check($sformatf("mem con row%0d", i), bus.con_out, mv[i].exp_con);
      end
      check("mailbox upper lanes no tx", {30'b0, tx_busy, ck_io7}, 32'd1);

      // Single byte
      clear_sched();
      sched_en[0] = 1'b1; sched_val[0] = 8'h55;
      exp_bytes.push_back(8'h55);
      run_stream("single", 1);

      // Back-to-back
      clear_sched();
      sched_en[0] = 1'b1; sched_val[0] = 8'h41;
      sched_en[1] = 1'b1; sched_val[1] = 8'h42;
      sched_en[2] = 1'b1; sched_val[2] = 8'h0A;
      exp_bytes.push_back(8'h41);
      exp_bytes.push_back(8'h42);
      exp_bytes.push_back(8'h0A);
      run_stream("b2b", 3);

      // Overflow: 0x80 starts the line, 0x00..0x10 fill the FIFO (0x00 is popped at
      // edge 11), 0x11 hits a full FIFO and is dropped, 0x12 meets a pop and is kept.
      clear_sched();
      sched_en[0] = 1'b1; sched_val[0] = 8'h80;
      exp_bytes.push_back(8'h80);
      for (int i = 0; i < 17; i++) begin
         sched_en[i+1]  = 1'b1;
         sched_val[i+1] = 8'(i);
         exp_bytes.push_back(8'(i));
      end
      sched_full[0] = 0; sched_full[15] = 0; sched_full[16] = 0; sched_full[17] = 1;
      sched_en[18] = 1'b1; sched_val[18] = 8'h11; sched_full[18] = 1;
      sched_full[20] = 1;
      sched_en[21] = 1'b1; sched_val[21] = 8'h12; sched_full[21] = 1;
      exp_bytes.push_back(8'h12);
      run_stream("ovf", 22);

      // Mid-frame reset with a second byte queued and a push during reset
      drive(4'b0001, TX, 32'h000000FF, TX);
      step();
      drive(4'b0001, TX, 32'h0000000F, TX);
      step();
      check("mfr start", {30'b0, tx_busy, ck_io7}, 32'd2);
      drive(4'b0000, 10'h000, 32'h0, TX);
      step();
      check("mfr bit0",   {31'b0, ck_io7}, 32'd1);
      check("mfr status", bus.con_out,     STAT_IDLE | 32'd1);
      repeat (4) step();
      check("mfr bit4", {31'b0, ck_io7}, 32'd1);
      nrst = 1'b0;
      drive(4'b0001, TX, 32'h00000033, TX);
      step();
      check("mfr rst line", {31'b0, ck_io7},  32'd1);
      check("mfr rst busy", {31'b0, tx_busy}, 32'd0);
      check("mfr rst full", {31'b0, tx_full}, 32'd0);
      nrst = 1'b1;
      drive(4'b0000, 10'h000, 32'h0, TX);
      for (int i = 0; i < 25; i++) begin
         step();
         check($sformatf("mfr quiet%0d", i), {30'b0, tx_busy, ck_io7}, 32'd1);
      end
      check("mfr post status", bus.con_out, STAT_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
